// File: rtl/detector_feed_sched.sv
// rtl/detector_feed_sched.sv - R/Y operand feeder and layer scheduler for a tree-search MIMO detector
//
// Loads an upper-triangular R matrix (NUM_R elements, shifted into r_flat so the
// first element ends in the MSB slot) and one Y vector per frame, then walks the
// detection tree from layer N_DIM down to 1, spending LAYER_CYC cycles per layer.
// R is reused across frames until reload_r requests a new matrix.
//
// Ports:
//   clk, rstn              clock; asynchronous reset, active-high
//   r_valid/r_data/r_ready R element stream (accepted in LOAD_R only)
//   y_valid/y_data/y_ready Y sample stream, y_N first (accepted in LOAD_Y only)
//   reload_r               request a fresh R matrix after the current frame
//   r_flat, r_loaded       stored matrix and its completeness flag
//   layer_start            first cycle of each layer slot
//   layer_idx, y_cur       current layer (0 outside RUN) and its Y sample
//   done, frame_cnt        end-of-frame pulse and completed-frame counter
module detector_feed_sched #(
   parameter int N_DIM     = 8,
   parameter int R_W       = 8,
   parameter int Y_W       = 12,
   parameter int LAYER_CYC = 4,
   localparam int NUM_R    = N_DIM * (N_DIM + 1) / 2,
   localparam int IDX_W    = $clog2(N_DIM + 1)
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   r_valid,
   input  logic [R_W-1:0]         r_data,
   output logic                   r_ready,
   input  logic                   y_valid,
   input  logic [Y_W-1:0]         y_data,
   output logic                   y_ready,
   input  logic                   reload_r,
   output logic [R_W*NUM_R-1:0]   r_flat,
   output logic                   r_loaded,
   output logic                   layer_start,
   output logic [IDX_W-1:0]       layer_idx,
   output logic [Y_W-1:0]         y_cur,
   output logic                   done,
   output logic [15:0]            frame_cnt
);

   localparam int RC_W   = $clog2(NUM_R);
   localparam int SLOT_W = $clog2(N_DIM);
   localparam int CYC_W  = $clog2(LAYER_CYC);

   localparam logic [RC_W-1:0]   R_LAST    = RC_W'(NUM_R - 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(N_DIM - 1);
   localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(LAYER_CYC - 1);

   typedef enum logic [1:0] {S_LOAD_R, S_LOAD_Y, S_RUN, S_DONE} state_t;

   state_t            state, state_nx;
   logic [RC_W-1:0]   r_cnt;
   logic [SLOT_W-1:0] y_cnt;
   logic [SLOT_W-1:0] slot;
   logic [CYC_W-1:0]  cyc;
   logic [Y_W-1:0]    y_mem [N_DIM];
   logic [Y_W-1:0]    y_hold;
   logic              pending;
   logic              r_fire, y_fire, run_last, enter_load_r;

   always_comb begin
      r_ready      = (state == S_LOAD_R);
      y_ready      = (state == S_LOAD_Y);
      r_fire       = r_valid && r_ready;
      y_fire       = y_valid && y_ready;
      run_last     = (state == S_RUN) && (slot == SLOT_LAST) && (cyc == CYC_LAST);
      layer_start  = 1'b0;
      layer_idx    = '0;
      y_cur        = y_hold;   // holds the last layer's sample outside RUN
      done         = 1'b0;
      state_nx     = state;
      case (state)
         S_LOAD_R: if (r_fire && (r_cnt == R_LAST)) state_nx = S_LOAD_Y;
         S_LOAD_Y: if (y_fire && (y_cnt == SLOT_LAST)) state_nx = S_LOAD_Y == S_LOAD_Y ? S_RUN : S_RUN;
         S_RUN: begin
            layer_start = (cyc == '0);
            layer_idx   = IDX_W'(N_DIM) - IDX_W'(slot);
            y_cur       = y_mem[slot];
            if (run_last) state_nx = S_DONE;
         end
         S_DONE: begin
            done     = 1'b1;
            // a request arriving in the DONE cycle itself still takes effect
            state_nx = (pending || reload_r) ? S_LOAD_R : S_LOAD_Y;
         end
         default: state_nx = S_LOAD_R;
      endcase
      enter_load_r = (state == S_DONE) && (state_nx == S_LOAD_R);
   end

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state     <= S_LOAD_R;
         r_flat    <= '0;
         r_loaded  <= 1'b0;
         r_cnt     <= '0;
         y_cnt     <= '0;
         slot      <= '0;
         cyc       <= '0;
         pending   <= 1'b0;
         frame_cnt <= '0;
         y_hold    <= '0;
         for (int i = 0; i < N_DIM; i++) y_mem[i] <= '0;
      end else begin
         state  <= state_nx;
         y_hold <= y_cur;

         // oldest element migrates toward the MSB end
         if (r_fire) begin
            r_flat <= {r_flat[R_W*(NUM_R-1)-1:0], r_data};
            if (r_cnt == R_LAST) begin
               r_cnt    <= '0;
               r_loaded <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end

         if (enter_load_r) begin
            r_loaded <= 1'b0;
            r_cnt    <= '0;
            pending  <= 1'b0;
         end else if (reload_r && (state != S_LOAD_R)) begin
            pending <= 1'b1;
         end

         // y_mem[0] holds y_N, so slot k reads y_(N_DIM-k) directly
         if (y_fire) begin
            y_mem[y_cnt] <= y_data;
            y_cnt        <= (y_cnt == SLOT_LAST) ? '0 : y_cnt + 1'b1;
         end

         if (state == S_RUN) begin
            if (cyc == CYC_LAST) begin
               cyc  <= '0;
               slot <= run_last ? '0 : slot + 1'b1;
            end else begin
               cyc <= cyc + 1'b1;
            end
         end

         if (run_last) frame_cnt <= frame_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_detector_feed_sched.sv
// tb/tb_detector_feed_sched.sv - self-checking bench for detector_feed_sched
`timescale 1ns/1ps
module tb_detector_feed_sched;

   localparam int N  = 8;
   localparam int RW = 8;
   localparam int YW = 12;
   localparam int LC = 4;
   localparam int NR = 36;
   localparam int IW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rstn = 1'b1;
   logic             r_valid = 1'b0;
   logic [RW-1:0]    r_data = '0;
   logic             r_ready;
   logic             y_valid = 1'b0;
   logic [YW-1:0]    y_data = '0;
   logic             y_ready;
   logic             reload_r = 1'b0;
   logic [RW*NR-1:0] r_flat;
   logic             r_loaded;
   logic             layer_start;
   logic [IW-1:0]    layer_idx;
   logic [YW-1:0]    y_cur;
   logic             done;
   logic [15:0]      frame_cnt;

   logic             rstn2 = 1'b1;
   logic             r_valid2 = 1'b0;
   logic [7:0]       r_data2 = '0;
   logic             r_ready2;
   logic             y_valid2 = 1'b0;
   logic [11:0]      y_data2 = '0;
   logic             y_ready2;
   logic             reload_r2 = 1'b0;
   logic [79:0]      r_flat2;
   logic             r_loaded2;
   logic             layer_start2;
   logic [2:0]       layer_idx2;
   logic [11:0]      y_cur2;
   logic             done2;
   logic [15:0]      frame_cnt2;

   detector_feed_sched dut (
      .clk(clk), .rstn(rstn),
      .r_valid(r_valid), .r_data(r_data), .r_ready(r_ready),
      .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready),
      .reload_r(reload_r), .r_flat(r_flat), .r_loaded(r_loaded),
      .layer_start(layer_start), .layer_idx(layer_idx), .y_cur(y_cur),
      .done(done), .frame_cnt(frame_cnt)
   );

   detector_feed_sched #(.N_DIM(4), .R_W(8), .Y_W(12), .LAYER_CYC(2)) dut2 (
      .clk(clk), .rstn(rstn2),
      .r_valid(r_valid2), .r_data(r_data2), .r_ready(r_ready2),
      .y_valid(y_valid2), .y_data(y_data2), .y_ready(y_ready2),
      .reload_r(reload_r2), .r_flat(r_flat2), .r_loaded(r_loaded2),
      .layer_start(layer_start2), .layer_idx(layer_idx2), .y_cur(y_cur2),
      .done(done2), .frame_cnt(frame_cnt2)
   );

   int checks = 0;
   int errors = 0;

   logic [RW-1:0] r_q [$];
   int            idx_q [$];
   logic [YW-1:0] y_q [$];

   task automatic drive_r(input logic [RW-1:0] d, input int gap);
      int n;
      r_valid = 1'b0;
      repeat ($urandom_range(0, gap)) @(negedge clk);
      r_valid = 1'b1;
      r_data  = d;
      n = 0;
      while (r_ready !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (r_ready !== 1'b1) begin
         errors++;
         $display("FAIL r_handshake: r_ready=%b after %0d cycles, required 1", r_ready, n);
      end
      @(negedge clk);
      r_valid = 1'b0;
   endtask

   task automatic drive_y(input logic [YW-1:0] d, input int gap);
      int n;
      y_valid = 1'b0;
      repeat ($urandom_range(0, gap)) @(negedge clk);
      y_valid = 1'b1;
      y_data  = d;
      n = 0;
      while (y_ready !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (y_ready !== 1'b1) begin
         errors++;
         $display("FAIL y_handshake: y_ready=%b after %0d cycles, required 1", y_ready, n);
      end
      @(negedge clk);
      y_valid = 1'b0;
   endtask

   task automatic load_r_all(input logic [RW-1:0] base, input int gap);
      for (int i = 0; i < NR; i++) begin
         logic [RW-1:0] d;
         d = base + RW'(i);
         r_q.push_back(d);
         drive_r(d, gap);
      end
      checks++;
      if (r_loaded !== 1'b1) begin
         errors++;
         $display("FAIL r_loaded_set: got %b, required 1", r_loaded);
      end
      checks++;
      if (y_ready !== 1'b1) begin
         errors++;
         $display("FAIL y_ready_after_load: got %b, required 1", y_ready);
      end
      for (int i = 0; i < NR; i++) begin
         logic [RW-1:0] e;
         e = r_q.pop_front();
         checks++;
         if (r_flat[RW*(NR-i)-1 -: RW] !== e) begin
            errors++;
            $display("FAIL r_flat_slot%0d: got %h, required %h", i, r_flat[RW*(NR-i)-1 -: RW], e);
         end
      end
   endtask

   task automatic load_y_all(input int gap, input bit ramp);
      for (int k = 0; k < N; k++) begin
         logic [YW-1:0] v;
         v = ramp ? YW'(N - k) : YW'($urandom_range(0, 4095));
         idx_q.push_back(N - k);
         y_q.push_back(v);
         drive_y(v, gap);
      end
   endtask

   task automatic run_frame(input logic [15:0] exp_fc, input int reload_slot);
      int n = 0, run_cyc = 0, starts = 0, last_start = -1, cur_idx = 0;
      logic [YW-1:0] cur_y = '0;
      while (done !== 1'b1 && n < 400) begin
         reload_r = 1'b0;
         checks++;
         if (r_ready !== 1'b0) begin
            errors++;
            $display("FAIL r_ready_busy: got %b, required 0", r_ready);
         end
         if (layer_start === 1'b1) begin
            checks++;
            if (idx_q.size() == 0) begin
               errors++;
               $display("FAIL extra_slot: slot %0d with empty scoreboard, required %0d slots", starts, N);
            end else begin
               cur_idx = idx_q.pop_front();
               cur_y   = y_q.pop_front();
            end
            if (last_start >= 0) begin
               checks++;
               if (run_cyc - last_start != LC) begin
                  errors++;
                  $display("FAIL start_spacing: got %0d, required %0d", run_cyc - last_start, LC);
               end
            end
            last_start = run_cyc;
            if (starts == reload_slot) reload_r = 1'b1;
            starts++;
         end
         if (layer_idx != '0) begin
            checks++;
            if (layer_idx !== IW'(cur_idx) || y_cur !== cur_y) begin
               errors++;
               $display("FAIL slot_data: layer_idx=%0d y_cur=%h, required %0d %h", layer_idx, y_cur, cur_idx, cur_y);
            end
            run_cyc++;
         end
         @(negedge clk);
         n++;
      end
      reload_r = 1'b0;
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL done_timeout: done=%b, required 1", done);
      end
      checks++;
      if (run_cyc != N * LC || starts != N) begin
         errors++;
         $display("FAIL run_length: cycles=%0d starts=%0d, required %0d %0d", run_cyc, starts, N * LC, N);
      end
      checks++;
      if (frame_cnt !== exp_fc) begin
         errors++;
         $display("FAIL frame_cnt: got %0d, required %0d", frame_cnt, exp_fc);
      end
      checks++;
      if (layer_idx !== '0 || layer_start !== 1'b0 || y_cur !== cur_y) begin
         errors++;
         $display("FAIL idle_outputs: idx=%0d start=%b y_cur=%h, required 0 0 %h", layer_idx, layer_start, y_cur, cur_y);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (r_flat !== '0 || r_loaded !== 1'b0 || frame_cnt !== 16'd0 || layer_start !== 1'b0 ||
          layer_idx !== '0 || y_cur !== '0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: loaded=%b fc=%0d start=%b idx=%0d y=%h done=%b, required all 0",
                  r_loaded, frame_cnt, layer_start, layer_idx, y_cur, done);
      end
      rstn  = 1'b0;
      rstn2 = 1'b0;
      @(negedge clk);
      checks++;
      if (r_ready !== 1'b1 || y_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_after_reset: r_ready=%b y_ready=%b, required 1 0", r_ready, y_ready);
      end
   endtask

   task automatic test_load_r();
      load_r_all(8'h01, 0);
   endtask

   task automatic test_frame();
      load_y_all(0, 1'b1);
      run_frame(16'd1, -1);
      @(negedge clk);
      checks++;
      if (y_ready !== 1'b1 || r_ready !== 1'b0) begin
         errors++;
         $display("FAIL back_to_load_y: y_ready=%b r_ready=%b, required 1 0", y_ready, r_ready);
      end
   endtask

   task automatic test_multi_frame();
      logic [RW*NR-1:0] saved;
      saved = r_flat;
      for (int f = 0; f < 2; f++) begin
         load_y_all(0, 1'b0);
         run_frame(16'(2 + f), -1);
         @(negedge clk);
      end
      checks++;
      if (r_flat !== saved || r_loaded !== 1'b1 || frame_cnt !== 16'd3) begin
         errors++;
         $display("FAIL r_retained: loaded=%b fc=%0d same=%b, required 1 3 1", r_loaded, frame_cnt, r_flat === saved);
      end
   endtask

   task automatic test_reload();
      load_y_all(0, 1'b0);
      run_frame(16'd4, 3);
      @(negedge clk);
      checks++;
      if (r_ready !== 1'b1 || r_loaded !== 1'b0 || y_ready !== 1'b0) begin
         errors++;
         $display("FAIL reload_entry: r_ready=%b r_loaded=%b y_ready=%b, required 1 0 0", r_ready, r_loaded, y_ready);
      end
   endtask

   task automatic test_gaps();
      y_valid = 1'b1;
      y_data  = 12'hFFF;
      load_r_all(8'h40, 3);
      y_valid = 1'b0;
      r_valid = 1'b1;
      r_data  = 8'hEE;
      load_y_all(3, 1'b0);
      run_frame(16'd5, -1);
      r_valid = 1'b0;
      checks++;
      if (r_flat[287:280] !== 8'h40 || r_flat[7:0] !== 8'h63) begin
         errors++;
         $display("FAIL gap_r_unchanged: msb=%h lsb=%h, required 40 63", r_flat[287:280], r_flat[7:0]);
      end
   endtask

   task automatic test_reset_mid_run();
      int n = 0;
      @(negedge clk);
      load_y_all(0, 1'b0);
      while (!(layer_start === 1'b1 && layer_idx === 4'd3) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (layer_idx !== 4'd3) begin
         errors++;
         $display("FAIL slot5_reach: layer_idx=%0d, required 3", layer_idx);
      end
      rstn = 1'b1;
      idx_q.delete();
      y_q.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || layer_start !== 1'b0 || layer_idx !== '0 || r_flat !== '0 ||
             r_loaded !== 1'b0 || frame_cnt !== 16'd0 || y_cur !== '0) begin
            errors++;
            $display("FAIL mid_run_reset: done=%b idx=%0d loaded=%b fc=%0d y=%h, required all 0",
                     done, layer_idx, r_loaded, frame_cnt, y_cur);
         end
      end
      rstn = 1'b0;
      @(negedge clk);
      checks++;
      if (r_ready !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL ready_after_mid_reset: r_ready=%b done=%b, required 1 0", r_ready, done);
      end
   endtask

   task automatic test_small_params();
      logic [7:0]  r2_q [$];
      logic [11:0] y2_q [$];
      int n, run_cyc, starts;
      rstn2 = 1'b1;
      repeat (2) @(negedge clk);
      rstn2 = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         r_valid2 = 1'b1;
         r_data2  = 8'h11 + 8'(i);
         r2_q.push_back(r_data2);
         n = 0;
         while (r_ready2 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
         @(negedge clk);
      end
      r_valid2 = 1'b0;
      checks++;
      if (r_loaded2 !== 1'b1) begin
         errors++;
         $display("FAIL small_r_loaded: got %b, required 1", r_loaded2);
      end
      for (int i = 0; i < 10; i++) begin
         logic [7:0] e;
         e = r2_q.pop_front();
         checks++;
         if (r_flat2[8*(10-i)-1 -: 8] !== e) begin
            errors++;
            $display("FAIL small_r_slot%0d: got %h, required %h", i, r_flat2[8*(10-i)-1 -: 8], e);
         end
      end
      for (int k = 0; k < 4; k++) begin
         y_valid2 = 1'b1;
         y_data2  = 12'h100 + 12'(k);
         y2_q.push_back(y_data2);
         n = 0;
         while (y_ready2 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
         @(negedge clk);
      end
      y_valid2 = 1'b0;
      n = 0; run_cyc = 0; starts = 0;
      while (done2 !== 1'b1 && n < 100) begin
         if (layer_start2 === 1'b1) begin
            logic [11:0] e;
            e = (y2_q.size() > 0) ? y2_q.pop_front() : 12'hXXX;
            checks++;
            if (y_cur2 !== e || layer_idx2 !== 3'(4 - starts)) begin
               errors++;
               $display("FAIL small_slot%0d: idx=%0d y=%h, required %0d %h", starts, layer_idx2, y_cur2, 4 - starts, e);
            end
            starts++;
         end
         if (layer_idx2 != '0) run_cyc++;
         @(negedge clk);
         n++;
      end
      checks++;
      if (done2 !== 1'b1 || run_cyc != 8 || starts != 4 || frame_cnt2 !== 16'd1) begin
         errors++;
         $display("FAIL small_run: done=%b cycles=%0d starts=%0d fc=%0d, required 1 8 4 1",
                  done2, run_cyc, starts, frame_cnt2);
      end
   endtask

   initial begin
      test_reset();
      test_load_r();
      test_frame();
      test_multi_frame();
      test_reload();
      test_gaps();
      test_reset_mid_run();
      test_small_params();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
